stream_write_master: RTL

Parametrised successor to the single-sample DDR3 stream writer. It captures a valid-qualified sample stream into an internal FIFO and drains it to DDR3 through an Avalon-MM master. Writes fully honour `ddr_waitrequest`. The block is configured and monitored through an Avalon-MM CSR slave, and supports one-shot or circular (wrap) capture, a programmable address step, a sample counter and a sticky overflow flag.

---
 rtl/stream_write_master_pkg.sv | 31 +++
 rtl/stream_write_master_sync_fifo.sv | 54 +++++
 rtl/stream_write_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_write_master_pkg.sv
// Shared definitions for the stream-to-DDR3 write master: CSR map, FSM states
// and status bit positions.
package stream_write_master_pkg;

  localparam logic [2:0] ADDR_BASE   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_STEP   = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_START  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_SRST   = 3'd6;
  localparam logic [2:0] ADDR_COUNT  = 3'd7;

  localparam int unsigned CSR_W = 32;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_BUSY = 1;
  localparam int unsigned STAT_OVF  = 2;
  localparam int unsigned STAT_WRAP = 3;

  localparam logic [CSR_W-1:0] DEADBEEF_RD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

endpackage

// File: rtl/stream_write_master_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush; push while full is
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_cnt;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/stream_write_master.sv
// Captures a valid-qualified sample stream into a FIFO and drains it to DDR3
// through an Avalon-MM master; configured through an Avalon-MM CSR slave.
module stream_write_master
  import stream_write_master_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_waitrequest,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  input  logic [2:0]        csr_addr,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [CSR_W-1:0]  csr_writedata,
  output logic [CSR_W-1:0]  csr_readdata,
  input  logic [DATA_W-1:0] d_in,
  input  logic              v,
  output logic              done
);

  state_e r_state, w_state_next;

  // Programmed CSR values and the copies latched at start
  logic [CSR_W-1:0]  r_csr_base, r_csr_len, r_csr_step;
  logic              r_csr_wrap;
  logic [CSR_W-1:0]  r_act_base, r_act_len, r_act_step;
  logic              r_act_wrap;

  logic [CSR_W-1:0]  r_acc;
  logic [CSR_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_wrapped;
  logic              r_done;
  logic [CSR_W-1:0]  r_rdata;

  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic              w_start, w_srst, w_accept, w_abort_exit;
  logic              w_push, w_load, w_ovf, w_flush, w_busy;
  logic              w_fifo_full, w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_head;
  logic [CSR_W-1:0]  w_status;

  assign w_start      = csr_write && (csr_addr == ADDR_START) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_srst       = csr_write && (csr_addr == ADDR_SRST);
  assign w_accept     = r_write && !ddr_waitrequest;
  assign w_abort_exit = (r_state == ST_ABORT) && !(r_write && ddr_waitrequest);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (d_in),
    .i_pop   (w_load),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_srst)       w_state_next = ST_ABORT;
        else if (w_start) w_state_next = (r_csr_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (w_srst) w_state_next = ST_ABORT;
        else if (!r_act_wrap && w_push && ((r_acc + 32'd1) == r_act_len))
          w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_srst) w_state_next = ST_ABORT;
        else if ((r_count == r_act_len) && w_fifo_empty && !r_write)
          w_state_next = ST_DONE;
      end
      ST_ABORT: begin
        if (w_abort_exit) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The bus slot is refilled from the FIFO head whenever it is free or retiring
  always_comb begin
    w_push  = 1'b0;
    w_load  = 1'b0;
    w_ovf   = 1'b0;
    w_flush = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: w_flush = 1'b1;
      ST_RUN: begin
        w_busy = 1'b1;
        w_load = !w_fifo_empty && (!r_write || w_accept);
        w_push = v && (r_acc < r_act_len) && (!w_fifo_full || w_load);
        w_ovf  = v && (r_acc < r_act_len) && w_fifo_full && !w_load;
      end
      ST_FLUSH: begin
        w_busy = 1'b1;
        w_load = !w_fifo_empty && (!r_write || w_accept);
      end
      ST_ABORT: begin
        w_busy  = 1'b1;
        w_flush = w_abort_exit;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_status            = '0;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_BUSY] = w_busy;
    w_status[STAT_OVF]  = r_ovf;
    w_status[STAT_WRAP] = r_wrapped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csr_base <= '0;
      r_csr_len  <= '0;
      r_csr_step <= 32'd1;
      r_csr_wrap <= 1'b0;
      r_act_base <= '0;
      r_act_len  <= '0;
      r_act_step <= 32'd1;
      r_act_wrap <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (csr_write) begin
        case (csr_addr)
          ADDR_BASE: r_csr_base <= csr_writedata;
          ADDR_LEN:  r_csr_len  <= csr_writedata;
          ADDR_STEP: r_csr_step <= csr_writedata;
          ADDR_CTRL: r_csr_wrap <= csr_writedata[0];
          default: ;
        endcase
      end
      if (w_start) begin
        r_act_base <= r_csr_base;
        r_act_len  <= r_csr_len;
        r_act_step <= r_csr_step;
        r_act_wrap <= r_csr_wrap;
      end
      if (csr_read) begin
        case (csr_addr)
          ADDR_BASE:   r_rdata <= r_csr_base;
          ADDR_LEN:    r_rdata <= r_csr_len;
          ADDR_STEP:   r_rdata <= r_csr_step;
          ADDR_CTRL:   r_rdata <= {31'd0, r_csr_wrap};
          ADDR_STATUS: r_rdata <= w_status;
          ADDR_COUNT:  r_rdata <= r_count;
          default:     r_rdata <= DEADBEEF_RD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (w_state_next == ST_DONE);
      if (w_load) begin
        r_wdata <= w_fifo_head;
        r_write <= 1'b1;
      end else if (w_accept) begin
        r_write <= 1'b0;
      end
      if (w_start) begin
        r_addr    <= ADDR_W'(r_csr_base);
        r_acc     <= '0;
        r_count   <= '0;
        r_ovf     <= 1'b0;
        r_wrapped <= 1'b0;
      end else begin
        if (w_push) r_acc <= r_acc + 32'd1;
        if (w_ovf)  r_ovf <= 1'b1;
        if (w_accept) begin
          // Circular capture restarts the window at base on the closing write
          if (r_act_wrap && ((r_count + 32'd1) == r_act_len)) begin
            r_addr    <= ADDR_W'(r_act_base);
            r_count   <= '0;
            r_acc     <= w_push ? 32'd1 : 32'd0;
            r_wrapped <= 1'b1;
          end else begin
            r_addr  <= r_addr + ADDR_W'(r_act_step);
            r_count <= r_count + 32'd1;
          end
        end
        if (w_abort_exit) begin
          r_acc     <= '0;
          r_count   <= '0;
          r_ovf     <= 1'b0;
          r_wrapped <= 1'b0;
        end
      end
    end
  end

  assign ddr_addr      = r_addr;
  assign ddr_write     = r_write;
  assign ddr_writedata = r_wdata;
  assign csr_readdata  = r_rdata;
  assign done          = r_done;

endmodule
